// File: rtl/hs_perf_monitor_pkg.sv
// Shared types and helpers for the hs_perf_monitor handshake performance monitor.
// Optional min/max latency tracking is enabled by defining HS_PERF_MONITOR_MINMAX_EN.
package hs_perf_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_CONT = 2'd2
  } ch_state_e;

  typedef enum logic [2:0] {
    SEL_TXN      = 3'd0,
    SEL_BUSY     = 3'd1,
    SEL_STALL    = 3'd2,
    SEL_LAT_LAST = 3'd3,
    SEL_LAT_MIN  = 3'd4,
    SEL_LAT_MAX  = 3'd5
  } rd_sel_e;

  localparam int SAT_MAX_W = 64;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] limit;
    limit = (width >= SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= limit) ? limit : value + 64'd1;
  endfunction

endpackage

// File: rtl/hs_perf_channel.sv
// One ap_ctrl handshake channel: IDLE/RUN/WAIT_CONT tracker with saturating counters.
// lat_min/lat_max ports and registers exist only when HS_PERF_MONITOR_MINMAX_EN is defined.
module hs_perf_channel
  import hs_perf_monitor_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LAT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             hold,
  input  logic             clear,
  output logic [CNT_W-1:0] txn,
  output logic [CNT_W-1:0] busy,
  output logic [CNT_W-1:0] stall,
  output logic [LAT_W-1:0] lat_last
`ifdef HS_PERF_MONITOR_MINMAX_EN
  ,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max
`endif
);

  ch_state_e        state;
  ch_state_e        state_next;
  logic             accept;
  logic             done_evt;
  logic             busy_evt;
  logic             stall_evt;
  logic [LAT_W-1:0] lat_cur;
  logic [LAT_W-1:0] lat_rec;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_evt   = 1'b0;
    lat_rec    = '0;
    case (state)
      IDLE: begin
        if (ap_start) begin
          accept = 1'b1;
          if (ap_done) begin
            done_evt   = 1'b1;
            lat_rec    = LAT_W'(1);
            state_next = ap_continue ? IDLE : WAIT_CONT;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (ap_done) begin
          // The done cycle itself counts toward latency.
          done_evt   = 1'b1;
          lat_rec    = LAT_W'(sat_inc(SAT_MAX_W'(lat_cur), LAT_W));
          state_next = ap_continue ? IDLE : WAIT_CONT;
        end
      end
      WAIT_CONT: begin
        if (ap_continue) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_evt  = accept || (state == RUN);
  assign stall_evt = (state == WAIT_CONT) && !ap_continue;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state <= IDLE;
    end else if (!hold) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      txn      <= '0;
      busy     <= '0;
      stall    <= '0;
      lat_cur  <= '0;
      lat_last <= '0;
    end else if (!hold) begin
      if (done_evt)  txn   <= CNT_W'(sat_inc(SAT_MAX_W'(txn), CNT_W));
      if (busy_evt)  busy  <= CNT_W'(sat_inc(SAT_MAX_W'(busy), CNT_W));
      if (stall_evt) stall <= CNT_W'(sat_inc(SAT_MAX_W'(stall), CNT_W));
      if (accept && !ap_done) begin
        lat_cur <= LAT_W'(1);
      end else if (state == RUN) begin
        lat_cur <= LAT_W'(sat_inc(SAT_MAX_W'(lat_cur), LAT_W));
      end
      if (done_evt) lat_last <= lat_rec;
    end
  end

`ifdef HS_PERF_MONITOR_MINMAX_EN
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (!hold && done_evt) begin
      if (lat_rec < lat_min) lat_min <= lat_rec;
      if (lat_rec > lat_max) lat_max <= lat_rec;
    end
  end
`endif

endmodule

// File: rtl/hs_perf_monitor.sv
// N-channel ap_ctrl handshake performance monitor with freeze/clear and a registered readout port.
// Define HS_PERF_MONITOR_MINMAX_EN to build per-channel min/max latency tracking (rd_sel 4/5).
module hs_perf_monitor
  import hs_perf_monitor_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int LAT_W  = 24
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ap_start,
  input  logic [NUM_CH-1:0]         ap_done,
  input  logic [NUM_CH-1:0]         ap_continue,
  input  logic                      finish,
  input  logic                      clear,
  input  logic                      rd_req,
  input  logic [$clog2(NUM_CH):0]   rd_ch,
  input  logic [2:0]                rd_sel,
  output logic                      rd_valid,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      rd_err,
  output logic                      frozen
);

  logic [CNT_W-1:0] txn_a      [NUM_CH];
  logic [CNT_W-1:0] busy_a     [NUM_CH];
  logic [CNT_W-1:0] stall_a    [NUM_CH];
  logic [LAT_W-1:0] lat_last_a [NUM_CH];
`ifdef HS_PERF_MONITOR_MINMAX_EN
  logic [LAT_W-1:0] lat_min_a  [NUM_CH];
  logic [LAT_W-1:0] lat_max_a  [NUM_CH];
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    hs_perf_channel #(
      .CNT_W (CNT_W),
      .LAT_W (LAT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .ap_start    (ap_start[gi]),
      .ap_done     (ap_done[gi]),
      .ap_continue (ap_continue[gi]),
      .hold        (frozen),
      .clear       (clear),
      .txn         (txn_a[gi]),
      .busy        (busy_a[gi]),
      .stall       (stall_a[gi]),
      .lat_last    (lat_last_a[gi])
`ifdef HS_PERF_MONITOR_MINMAX_EN
      ,
      .lat_min     (lat_min_a[gi]),
      .lat_max     (lat_max_a[gi])
`endif
    );
  end

  // Sticky freeze; clear has priority so a simultaneous finish is dropped.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      frozen <= 1'b0;
    end else if (finish) begin
      frozen <= 1'b1;
    end
  end

  logic [SAT_MAX_W-1:0] rd_data_p0;
  logic [SAT_MAX_W-1:0] pick_p0;
  logic                 ch_hit_p0;
  logic                 sel_ok_p0;
  logic                 rd_err_p0;

  // Stage p0: combinational channel/counter select.
  always_comb begin
    pick_p0   = '0;
    ch_hit_p0 = 1'b0;
    sel_ok_p0 = 1'b0;
    case (rd_sel_e'(rd_sel))
      SEL_TXN, SEL_BUSY, SEL_STALL, SEL_LAT_LAST: sel_ok_p0 = 1'b1;
`ifdef HS_PERF_MONITOR_MINMAX_EN
      SEL_LAT_MIN, SEL_LAT_MAX:                   sel_ok_p0 = 1'b1;
`else
      SEL_LAT_MIN, SEL_LAT_MAX:                   sel_ok_p0 = 1'b0;
`endif
      default:                                    sel_ok_p0 = 1'b0;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_ch) == i) begin
        ch_hit_p0 = 1'b1;
        case (rd_sel_e'(rd_sel))
          SEL_TXN:      pick_p0 = SAT_MAX_W'(txn_a[i]);
          SEL_BUSY:     pick_p0 = SAT_MAX_W'(busy_a[i]);
          SEL_STALL:    pick_p0 = SAT_MAX_W'(stall_a[i]);
          SEL_LAT_LAST: pick_p0 = SAT_MAX_W'(lat_last_a[i]);
`ifdef HS_PERF_MONITOR_MINMAX_EN
          SEL_LAT_MIN:  pick_p0 = SAT_MAX_W'(lat_min_a[i]);
          SEL_LAT_MAX:  pick_p0 = SAT_MAX_W'(lat_max_a[i]);
`endif
          default:      pick_p0 = '0;
        endcase
      end
    end
    rd_err_p0  = !ch_hit_p0 || !sel_ok_p0;
    rd_data_p0 = rd_err_p0 ? '0 : pick_p0;
  end

  // Stage p1: registered response, one cycle after the request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= CNT_W'(rd_data_p0);
        rd_err  <= rd_err_p0;
      end
    end
  end

endmodule
